// File: rtl/ram_responder.sv
// Word-addressed RAM responder: one read or write at a time, byte-masked writes, sticky range error.
// Latency RD_LATENCY/WR_LATENCY edges to a one-cycle rvalid/wready pulse; a held request waits in RELEASE until dropped.
module ram_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          RD_LATENCY  = 2,
    parameter int          WR_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] raddr,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic        wen,
    input  logic [3:0]  sel,
    output logic        wready,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_WR_WAIT,
        S_RESP,
        S_RELEASE
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_is_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_sel;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [31:0] w_idx;
    logic        w_in_range;
    logic        w_commit;

    // Addresses below ADDR_BASE wrap to a huge index and fall out of range.
    assign w_idx      = (r_addr - ADDR_BASE) >> 2;
    assign w_in_range = (w_idx < 32'(DEPTH_WORDS));
    assign w_commit   = (r_state == S_WR_WAIT) && (r_cnt == 4'd0) && w_in_range;

    // Storage has no reset; a reset before the commit edge leaves the FSM idle, so nothing lands.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_sel[i]) begin
                    r_mem[w_idx[AW-1:0]][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_is_wr <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_sel   <= 4'd0;
            rdata   <= 32'd0;
            rvalid  <= 1'b0;
            wready  <= 1'b0;
            err     <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            wready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wen) begin
                        r_is_wr <= 1'b1;
                        r_addr  <= waddr;
                        r_wdata <= wdata;
                        r_sel   <= sel;
                        r_cnt   <= 4'(WR_LATENCY - 1);
                        r_state <= S_WR_WAIT;
                    end else if (ren) begin
                        r_is_wr <= 1'b0;
                        r_addr  <= raddr;
                        r_cnt   <= 4'(RD_LATENCY - 1);
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        rvalid  <= 1'b1;
                        rdata   <= w_in_range ? r_mem[w_idx[AW-1:0]] : 32'hDEAD_BEEF;
                        if (!w_in_range) err <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_WR_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        wready  <= 1'b1;
                        if (!w_in_range) err <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (r_is_wr ? !wen : !ren) r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: vector table on a default instance, hand sequences for
// simultaneous requests, held requests, and reset before a slow write commits.
module tb_ram_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, use_b;
    logic [31:0] raddr, waddr, wdata;
    logic        ren, wen;
    logic [3:0]  sel;

    logic        a_ren, a_wen, b_ren, b_wen;
    logic [31:0] a_rdata, b_rdata, rdata;
    logic        a_rvalid, b_rvalid, rvalid;
    logic        a_wready, b_wready, wready;
    logic        a_err, b_err, err;

    assign a_ren  = ren & ~use_b;
    assign a_wen  = wen & ~use_b;
    assign b_ren  = ren &  use_b;
    assign b_wen  = wen &  use_b;
    assign rdata  = use_b ? b_rdata  : a_rdata;
    assign rvalid = use_b ? b_rvalid : a_rvalid;
    assign wready = use_b ? b_wready : a_wready;
    assign err    = use_b ? b_err    : a_err;

    ram_responder #(.ADDR_BASE(32'h0000_0000), .DEPTH_WORDS(256), .RD_LATENCY(2), .WR_LATENCY(1)) u_a (
        .clk(clk), .rst(rst_a), .raddr(raddr), .ren(a_ren), .rdata(a_rdata), .rvalid(a_rvalid),
        .waddr(waddr), .wdata(wdata), .wen(a_wen), .sel(sel), .wready(a_wready), .err(a_err));

    ram_responder #(.ADDR_BASE(32'h0400_0000), .DEPTH_WORDS(16), .RD_LATENCY(1), .WR_LATENCY(3)) u_b (
        .clk(clk), .rst(rst_b), .raddr(raddr), .ren(b_ren), .rdata(b_rdata), .rvalid(b_rvalid),
        .waddr(waddr), .wdata(wdata), .wen(b_wen), .sel(sel), .wready(b_wready), .err(b_err));

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request, return edges from acceptance to pulse (-1 on timeout), leave FSM idle.
    task automatic xact(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] s, output int lat);
        @(negedge clk);
        if (wr) begin
            waddr = addr; wdata = data; sel = s; wen = 1'b1;
        end else begin
            raddr = addr; ren = 1'b1;
        end
        @(posedge clk); #1;
        waddr = ~addr; wdata = ~data; raddr = ~addr; sel = ~s;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (wr ? wready : rvalid) begin
                lat = n;
                break;
            end
        end
        wen = 1'b0;
        ren = 1'b0;
        @(posedge clk); #1;
        check32("pulse_one_cycle", 32'(wr ? wready : rvalid), 32'd0);
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(bit wr, logic [31:0] addr, logic [31:0] data, logic [3:0] s,
                                logic [31:0] exp_rd, logic exp_err);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.sel = s; v.exp_rd = exp_rd; v.exp_err = exp_err;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt;
        rst_a = 1'b1; rst_b = 1'b1; use_b = 1'b0;
        raddr = '0; waddr = '0; wdata = '0; ren = 1'b0; wen = 1'b0; sel = '0;
        #1;
        check32("rst_rdata", rdata, 32'd0);
        check32("rst_rvalid", 32'(rvalid), 32'd0);
        check32("rst_wready", 32'(wready), 32'd0);
        check32("rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;

        vt.push_back(mk(1, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0));
        vt.push_back(mk(1, 32'h0000_0008, 32'h1234_5678, 4'hF, 32'h0, 1'b0));
        vt.push_back(mk(0, 32'h0000_0008, 32'h0,         4'h0, 32'h1234_5678, 1'b0));
        vt.push_back(mk(1, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0));
        vt.push_back(mk(1, 32'h0000_0010, 32'hAABB_CCDD, 4'h5, 32'h0, 1'b0));
        vt.push_back(mk(0, 32'h0000_0010, 32'h0,         4'h0, 32'hFFBB_FFDD, 1'b0));
        vt.push_back(mk(1, 32'h0000_000B, 32'h0000_0099, 4'h1, 32'h0, 1'b0));
        vt.push_back(mk(0, 32'h0000_0008, 32'h0,         4'h0, 32'h1234_5699, 1'b0));
        vt.push_back(mk(1, 32'h0000_03FC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0));
        vt.push_back(mk(0, 32'h0000_03FC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0));
        vt.push_back(mk(1, 32'h0000_0014, 32'h1111_1111, 4'hF, 32'h0, 1'b0));
        vt.push_back(mk(1, 32'h0000_0014, 32'h2222_2222, 4'h0, 32'h0, 1'b0));
        vt.push_back(mk(0, 32'h0000_0014, 32'h0,         4'h0, 32'h1111_1111, 1'b0));
        vt.push_back(mk(0, 32'h0000_0400, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b1));
        vt.push_back(mk(1, 32'h0000_0400, 32'h7777_7777, 4'hF, 32'h0, 1'b1));
        vt.push_back(mk(0, 32'h0000_0000, 32'h0,         4'h0, 32'hA5A5_A5A5, 1'b1));
        vt.push_back(mk(0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b1));
        vt.push_back(mk(0, 32'h0000_0008, 32'h0,         4'h0, 32'h1234_5699, 1'b1));

        foreach (vt[i]) begin
            xact(vt[i].wr, vt[i].addr, vt[i].data, vt[i].sel, lat);
            check32($sformatf("lat[%0d]", i), lat, vt[i].wr ? 32'd1 : 32'd2);
            if (!vt[i].wr) check32($sformatf("rdata[%0d]", i), rdata, vt[i].exp_rd);
            check32($sformatf("err[%0d]", i), 32'(err), 32'(vt[i].exp_err));
        end

        // Simultaneous write and read to one word: write first, then the read sees the new data.
        xact(1, 32'h0000_0020, 32'h0, 4'hF, lat);
        @(negedge clk);
        waddr = 32'h0000_0020; wdata = 32'h5; sel = 4'hF; raddr = 32'h0000_0020;
        wen = 1'b1; ren = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            @(posedge clk); #1;
            check32($sformatf("both_wready[%0d]", e), 32'(wready), 32'(e == 1));
            check32($sformatf("both_rvalid[%0d]", e), 32'(rvalid), 32'(e == 8));
            if (e == 8) check32("both_rdata", rdata, 32'h5);
            if (e == 4) wen = 1'b0;
        end
        ren = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Held read: one pulse per rising request.
        @(negedge clk);
        raddr = 32'h0000_0008; ren = 1'b1;
        cnt = 0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            if (rvalid) cnt++;
        end
        check32("held_pulses", cnt, 32'd1);
        ren = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ren = 1'b1;
        cnt = 0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            if (rvalid) cnt++;
        end
        check32("rerise_pulses", cnt, 32'd1);
        check32("rerise_rdata", rdata, 32'h1234_5699);
        ren = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Slow-write instance: below-base read, then reset one edge before the write commit.
        use_b = 1'b1;
        xact(1, 32'h0400_0004, 32'h0BAD_C0DE, 4'hF, lat);
        check32("b_wr_lat", lat, 32'd3);
        xact(0, 32'h03FF_FFFC, 32'h0, 4'h0, lat);
        check32("b_below_lat", lat, 32'd1);
        check32("b_below_rdata", rdata, 32'hDEAD_BEEF);
        check32("b_below_err", 32'(err), 32'd1);
        @(negedge clk);
        waddr = 32'h0400_0004; wdata = 32'h1122_3344; sel = 4'hF; wen = 1'b1;
        @(posedge clk); #1;
        wen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check32("b_pre_rst_wready", 32'(wready), 32'd0);
        rst_b = 1'b1;
        #1;
        check32("b_rst_err", 32'(err), 32'd0);
        check32("b_rst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        check32("b_commit_wready", 32'(wready), 32'd0);
        @(negedge clk);
        rst_b = 1'b0;
        cnt = 0;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk); #1;
            if (wready) cnt++;
        end
        check32("b_no_wready", cnt, 32'd0);
        xact(0, 32'h0400_0004, 32'h0, 4'h0, lat);
        check32("b_rd_lat", lat, 32'd1);
        check32("b_old_word", rdata, 32'h0BAD_C0DE);
        check32("b_err_after", 32'(err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_responder.md
# ram_responder

Synthesizable responder for the mapped-RAM port that the lab top drives as initiator (`ramN_raddr/ren/rdata/rvalid`, `ramN_waddr/wdata/wen/sel/wready`). It holds a word-addressed register-array memory, accepts one read or write at a time, and answers with a single-cycle `rvalid`/`wready` pulse after a programmable latency. It stands in for the platform RAM0/RAM1 in simulation and on-board loopback, so CPU memory paths can be exercised before the real mapped RAM is used.

## Interface
- `ADDR_BASE`, 32'h0000_0000, byte address of word 0 (RAM0 = 32'h0000_0000, RAM1 = 32'h0400_0000)
- `DEPTH_WORDS`, 256, number of 32-bit words; power of two, 16..4096
- `RD_LATENCY`, 2, cycles from read acceptance to `rvalid`; legal range 1..15
- `WR_LATENCY`, 1, cycles from write acceptance to `wready`; legal range 1..15
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `raddr`  in  32  read byte address; bits [1:0] ignored
- `ren`  in  1  read request level
- `rdata`  out  32  read data; valid when `rvalid`=1, holds last value otherwise
- `rvalid`  out  1  one-cycle read completion pulse
- `waddr`  in  32  write byte address; bits [1:0] ignored
- `wdata`  in  32  write data
- `wen`  in  1  write request level
- `sel`  in  4  byte enables; `sel[i]` writes `wdata[8i+7:8i]`
- `wready`  out  1  one-cycle write completion pulse
- `err`  out  1  sticky: set on any out-of-range access, cleared only by `rst`

## Operation
- Single FSM: IDLE, RD_WAIT, WR_WAIT, RESP, RELEASE.
- IDLE: if `wen`=1, latch `waddr`/`wdata`/`sel`, load counter with WR_LATENCY-1, go to WR_WAIT; else if `ren`=1, latch `raddr`, load counter with RD_LATENCY-1, go to RD_WAIT. Write has priority when `wen` and `ren` are both high; the read is served after the write completes.
- RD_WAIT/WR_WAIT: decrement counter; at 0 go to RESP. On that same edge: read drives `rdata` from memory and `rvalid`=1; write commits the masked bytes to memory and drives `wready`=1.
- RESP: lasts exactly one cycle; pulse deasserts; go to RELEASE.
- RELEASE: wait until the request that was served (`ren` or `wen`) is low, then go to IDLE. A held request is never served twice. In this state the other request is ignored until IDLE.
- Index = (addr - ADDR_BASE) >> 2, computed in 32 bits, unsigned. The access is in range when the index is < DEPTH_WORDS. An address below ADDR_BASE wraps to a large index and is out of range.
- Out-of-range read: `rdata` = 32'hDEAD_BEEF, `err` set. Out-of-range write: memory unchanged, `err` set. Both still complete the handshake with normal latency.
- `sel`=4'b0000 write: handshake completes, memory unchanged, no error.
- Memory contents are not cleared by `rst`; they are X after power-up in simulation.

## Timing
- Reset values: `rdata`=0, `rvalid`=0, `wready`=0, `err`=0, state IDLE, counter 0.
- The request is sampled at edge k in IDLE. The pulse is high after edge k+L and low after edge k+L+1 (L = RD_LATENCY or WR_LATENCY).
- Back-to-back throughput: if the request drops in the pulse cycle, RELEASE exits at edge k+L+2. The next acceptance is possible at edge k+L+3.
- Latched address/data are used, so the initiator may change `waddr`/`wdata` after acceptance.
- `rst` asserted mid-transaction: immediate return to IDLE and pulses forced low. A write not yet at its commit edge is dropped, with no partial byte update. `err` clears.
- The write commit and the `wready` assertion occur on the same edge. A read accepted later observes the written data.

## Test plan
- Reset, then write 32'h1234_5678 to ADDR_BASE+8 with `sel`=4'hF, then read it back with defaults. Required: `wready` after 1 edge, `rvalid` exactly 2 edges after acceptance, `rdata`=32'h1234_5678, `err`=0.
- Byte mask: preload 32'hFFFF_FFFF, write 32'hAABB_CCDD with `sel`=4'b0101, then read. Required: `rdata`=32'hFFBB_FFDD.
- `ren` and `wen` both high in one cycle on the same word (old 0, new 32'h5). Required: `wready` first, then `rvalid` with 32'h5. Each pulse lasts one cycle only while the requests are held.
- Read `ADDR_BASE`+4*DEPTH_WORDS, then read `ADDR_BASE`-4. Required: both return 32'hDEAD_BEEF, `err`=1 and stays 1 after later valid accesses.
- `ren` held high for 10 cycles. Required: exactly one `rvalid` pulse; a second pulse only after `ren` has dropped and risen again.
- Assert `rst` one cycle before the commit edge of a write with `WR_LATENCY`=3. Required: no `wready` and the old word intact on readback; `err` cleared.
